// File: rtl/pad_filter.sv
// Rebuilds a full OUT_ROWS x OUT_COLS raster from a cropped window stream, filling outside pixels with PAD_VALUE.
// Optional macro PAD_FILTER_TLAST_EN adds a registered pixel_out_TLAST flag on the last pixel of each frame.
module pad_filter #(
   parameter int                         PIXEL_BIT_WIDTH = 12,
   parameter int                         IN_ROWS         = 20,
   parameter int                         IN_COLS         = 20,
   parameter int                         OUT_ROWS        = 40,
   parameter int                         OUT_COLS        = 40,
   parameter int                         Y_1             = 10,
   parameter int                         X_1             = 10,
   parameter logic [PIXEL_BIT_WIDTH-1:0] PAD_VALUE       = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in_TDATA,
   input  logic                       pixel_in_TVALID,
   output logic                       pixel_in_TREADY,
   output logic [PIXEL_BIT_WIDTH-1:0] pixel_out_TDATA,
   output logic                       pixel_out_TVALID,
`ifdef PAD_FILTER_TLAST_EN
   output logic                       pixel_out_TLAST,
`endif
   input  logic                       pixel_out_TREADY
);

   localparam int ROW_W = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
   localparam int COL_W = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_ROWS - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_COLS - 1);

   logic [ROW_W-1:0]           row_q, row_d;
   logic [COL_W-1:0]           col_q, col_d;
   logic [PIXEL_BIT_WIDTH-1:0] data_q, data_d;
   logic                       valid_q, valid_d;
   logic                       slot_free;
   logic                       in_window;
   logic                       advance;

`ifdef PAD_FILTER_TLAST_EN
   logic last_q, last_d;
   logic at_last_pos;
   assign at_last_pos = (row_q == ROW_LAST) && (col_q == COL_LAST);
`endif

   // Window bounds are compared in 32-bit signed space so Y_1+IN_ROWS may equal OUT_ROWS.
   assign in_window = (int'(row_q) >= Y_1) && (int'(row_q) < Y_1 + IN_ROWS) &&
                      (int'(col_q) >= X_1) && (int'(col_q) < X_1 + IN_COLS);

   assign slot_free       = !valid_q || pixel_out_TREADY;
   assign pixel_in_TREADY = slot_free && in_window && !reset;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      advance = 1'b0;
`ifdef PAD_FILTER_TLAST_EN
      last_d  = last_q;
`endif
      if (slot_free) begin
         if (!in_window) begin
            data_d  = PAD_VALUE;
            valid_d = 1'b1;
            advance = 1'b1;
         end else if (pixel_in_TVALID) begin
            data_d  = pixel_in_TDATA;
            valid_d = 1'b1;
            advance = 1'b1;
         end else begin
            valid_d = 1'b0;
         end
`ifdef PAD_FILTER_TLAST_EN
         last_d = advance && at_last_pos;
`endif
      end
   end

   // Column runs fastest; the frame wraps straight back to (0,0) with no gap.
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (advance) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
               row_d = '0;
            end else begin
               row_d = row_q + ROW_W'(1);
            end
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         row_q   <= '0;
         col_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
`ifdef PAD_FILTER_TLAST_EN
         last_q  <= 1'b0;
`endif
      end else begin
         row_q   <= row_d;
         col_q   <= col_d;
         data_q  <= data_d;
         valid_q <= valid_d;
`ifdef PAD_FILTER_TLAST_EN
         last_q  <= last_d;
`endif
      end
   end

   assign pixel_out_TDATA  = data_q;
   assign pixel_out_TVALID = valid_q;
`ifdef PAD_FILTER_TLAST_EN
   assign pixel_out_TLAST  = last_q;
`endif

endmodule

// File: tb/tb_pad_filter.sv
// Directed self-checking bench for pad_filter on a 4x4 frame with a 2x2 window at (1,1), pad 12'hFFF.
// Define PAD_FILTER_TLAST_EN for both files to also check pixel_out_TLAST.
module tb_pad_filter;

   logic        clk;
   logic        reset;
   logic [11:0] pixel_in_TDATA;
   logic        pixel_in_TVALID;
   logic        pixel_in_TREADY;
   logic [11:0] pixel_out_TDATA;
   logic        pixel_out_TVALID;
   logic        pixel_out_TREADY;
`ifdef PAD_FILTER_TLAST_EN
   logic        pixel_out_TLAST;
`endif

   int numChecks;
   int numFails;
   int nextPix;

   // Hand-written expected frame for window pixels 1..4; later frames add 4 per frame to the window entries.
   logic [11:0] expFrame [16];
   logic        expReady [16];

   pad_filter #(
      .PIXEL_BIT_WIDTH(12),
      .IN_ROWS        (2),
      .IN_COLS        (2),
      .OUT_ROWS       (4),
      .OUT_COLS       (4),
      .Y_1            (1),
      .X_1            (1),
      .PAD_VALUE      (12'hFFF)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .pixel_in_TDATA  (pixel_in_TDATA),
      .pixel_in_TVALID (pixel_in_TVALID),
      .pixel_in_TREADY (pixel_in_TREADY),
      .pixel_out_TDATA (pixel_out_TDATA),
      .pixel_out_TVALID(pixel_out_TVALID),
`ifdef PAD_FILTER_TLAST_EN
      .pixel_out_TLAST (pixel_out_TLAST),
`endif
      .pixel_out_TREADY(pixel_out_TREADY)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      numChecks++;
      if (observed !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs, checks pixel_in_TREADY before the edge, and tracks consumed pixels.
   task automatic applyStimulus(input logic inValid, input logic outReady, input logic expInReady);
      logic handshake;
      pixel_in_TVALID  = inValid;
      pixel_out_TREADY = outReady;
      pixel_in_TDATA   = 12'(nextPix);
      #1;
      checkOutput("in_tready", 32'(pixel_in_TREADY), 32'(expInReady));
      handshake = pixel_in_TREADY && inValid;
      @(posedge clk);
      #1;
      if (handshake) nextPix++;
   endtask

   task automatic doReset(input bit restartPixels);
      reset            = 1'b1;
      pixel_in_TVALID  = 1'b0;
      pixel_out_TREADY = 1'b1;
      #1;
      checkOutput("in_tready_rst", 32'(pixel_in_TREADY), 32'd0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      checkOutput("rst_valid", 32'(pixel_out_TVALID), 32'd0);
      checkOutput("rst_data", 32'(pixel_out_TDATA), 32'd0);
`ifdef PAD_FILTER_TLAST_EN
      checkOutput("rst_tlast", 32'(pixel_out_TLAST), 32'd0);
`endif
      reset = 1'b0;
      if (restartPixels) nextPix = 1;
   endtask

   function automatic logic [11:0] expPix(int idx);
      int frame;
      frame = idx / 16;
      if (expFrame[idx % 16] == 12'hFFF) return 12'hFFF;
      return expFrame[idx % 16] + 12'(4 * frame);
   endfunction

   task automatic checkPixel(string tag, int idx);
      checkOutput({tag, "_valid"}, 32'(pixel_out_TVALID), 32'd1);
      checkOutput({tag, "_data"}, 32'(pixel_out_TDATA), 32'(expPix(idx)));
`ifdef PAD_FILTER_TLAST_EN
      checkOutput({tag, "_tlast"}, 32'(pixel_out_TLAST), 32'((idx % 16) == 15));
`endif
   endtask

   initial begin
      numChecks = 0;
      numFails  = 0;
      nextPix   = 1;
      expFrame  = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF,
                    12'hFFF, 12'd1,   12'd2,   12'hFFF,
                    12'hFFF, 12'd3,   12'd4,   12'hFFF,
                    12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
      expReady  = '{1'b0, 1'b0, 1'b0, 1'b0,
                    1'b0, 1'b1, 1'b1, 1'b0,
                    1'b0, 1'b1, 1'b1, 1'b0,
                    1'b0, 1'b0, 1'b0, 1'b0};
      reset            = 1'b1;
      pixel_in_TDATA   = '0;
      pixel_in_TVALID  = 1'b0;
      pixel_out_TREADY = 1'b1;

      $display("[TB] back-to-back frames, no stalls");
      doReset(1'b1);
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b1, 1'b1, expReady[i % 16]);
         checkPixel("stream", i);
      end

      $display("[TB] downstream stall on first window pixel");
      doReset(1'b1);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 1'b1, expReady[i]);
         checkPixel("prestall", i);
      end
      for (int s = 0; s < 3; s++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         checkPixel("stall", 5);
      end
      for (int i = 6; i < 16; i++) begin
         applyStimulus(1'b1, 1'b1, expReady[i]);
         checkPixel("poststall", i);
      end

      $display("[TB] upstream starvation at (1,1)");
      doReset(1'b1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
         checkPixel("starve_pad", i);
      end
      for (int s = 0; s < 4; s++) begin
         applyStimulus(1'b0, 1'b1, 1'b1);
         checkOutput("starve_gap", 32'(pixel_out_TVALID), 32'd0);
      end
      for (int i = 5; i < 16; i++) begin
         applyStimulus(1'b1, 1'b1, expReady[i]);
         checkPixel("resume", i);
      end

      $display("[TB] reset mid-frame");
      doReset(1'b1);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 1'b1, expReady[i]);
         checkPixel("prereset", i);
      end
      reset = 1'b1;
      #1;
      checkOutput("midrst_in_tready", 32'(pixel_in_TREADY), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("midrst_valid", 32'(pixel_out_TVALID), 32'd0);
      checkOutput("midrst_data", 32'(pixel_out_TDATA), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         checkPixel("restart_pad", i);
      end
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("restart_valid", 32'(pixel_out_TVALID), 32'd1);
      checkOutput("restart_data", 32'(pixel_out_TDATA), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule

// File: doc/pad_filter.md
PAD_FILTER -- requirements
Module: pad_filter

Interface
REQ-001 PIXEL_BIT_WIDTH, default 12: pixel data width in bits.
REQ-002 IN_ROWS, default 20: rows of the incoming cropped window.
REQ-003 IN_COLS, default 20: columns of the incoming cropped window.
REQ-004 OUT_ROWS, default 40: rows of the reconstructed output frame.
REQ-005 OUT_COLS, default 40: columns of the reconstructed output frame.
REQ-006 Y_1, default 10: output row where window row 0 is placed.
REQ-007 X_1, default 10: output column where window column 0 is placed.
REQ-008 PAD_VALUE, default 0: PIXEL_BIT_WIDTH-bit fill value for pixels outside the window.
REQ-009 clk  input  1  sole clock; all state updates on rising edge.
REQ-010 reset  input  1  synchronous, active-high reset.
REQ-011 pixel_in_TDATA  input  PIXEL_BIT_WIDTH  window pixel, raster order.
REQ-012 pixel_in_TVALID  input  1  upstream has a valid window pixel.
REQ-013 pixel_in_TREADY  output  1  block accepts pixel_in_TDATA this cycle.
REQ-014 pixel_out_TDATA  output  PIXEL_BIT_WIDTH  output frame pixel, raster order.
REQ-015 pixel_out_TVALID  output  1  pixel_out_TDATA is valid.
REQ-016 pixel_out_TREADY  input  1  downstream accepts the output pixel.

Function
REQ-017 Block SHALL be used only with Y_1+IN_ROWS <= OUT_ROWS and X_1+IN_COLS <= OUT_COLS; other settings are unsupported.
REQ-018 Block SHALL keep row/col counters over the output frame, width ceil(log2(OUT_ROWS)) / ceil(log2(OUT_COLS)), minimum 1 bit.
REQ-019 Position (row,col) SHALL be in-window iff Y_1 <= row < Y_1+IN_ROWS and X_1 <= col < X_1+IN_COLS.
REQ-020 Output SHALL be a single register stage (pixel_out_TDATA/pixel_out_TVALID registered); "slot free" = !pixel_out_TVALID || pixel_out_TREADY.
REQ-021 pixel_in_TREADY SHALL equal slot free AND current position in-window AND !reset (combinational).
REQ-022 Out-of-window position with slot free: load PAD_VALUE, set pixel_out_TVALID, advance counters; input not consumed.
REQ-023 In-window position with slot free and pixel_in_TVALID: load pixel_in_TDATA, set pixel_out_TVALID, advance counters.
REQ-024 In-window position with slot free and !pixel_in_TVALID: clear pixel_out_TVALID, counters hold.
REQ-025 Slot not free: pixel_out_TDATA, pixel_out_TVALID and counters SHALL hold unchanged.
REQ-026 Latency from input handshake to pixel_out_TVALID SHALL be exactly 1 cycle; sustained throughput 1 pixel/cycle.
REQ-027 Counters SHALL advance col first; col wraps OUT_COLS-1 -> 0 with row+1; (OUT_ROWS-1,OUT_COLS-1) wraps to (0,0) so frames run back-to-back with no idle cycle.
REQ-028 Exactly IN_ROWS*IN_COLS input pixels SHALL be consumed per output frame of OUT_ROWS*OUT_COLS pixels.

Reset
REQ-029 With reset high at a rising edge: pixel_out_TVALID=0, pixel_out_TDATA=0, row=0, col=0.
REQ-030 pixel_in_TREADY SHALL be 0 in every cycle reset is high.
REQ-031 Reset mid-frame SHALL abandon the frame; first output after reset is position (0,0).

Configuration
REQ-032 Macro PAD_FILTER_TLAST_EN defined: extra output pixel_out_TLAST (1 bit, registered with data, reset 0) SHALL be 1 exactly on the pixel at (OUT_ROWS-1,OUT_COLS-1), held under backpressure.
REQ-033 Macro undefined: no pixel_out_TLAST port exists; all other behaviour identical.

Verification (OUT 4x4, IN 2x2, Y_1=1, X_1=1, PAD_VALUE=12'hFFF)
REQ-034 Inputs 1,2,3,4 always valid, pixel_out_TREADY=1 -> 16 outputs: FFF x5, 1, 2, FFF x2, 3, 4, FFF x5; first TVALID one cycle after reset release.
REQ-035 pixel_out_TREADY low 3 cycles while output is 1 -> TDATA=1, TVALID=1 stable, pixel_in_TREADY=0, input 2 not consumed.
REQ-036 pixel_in_TVALID low 4 cycles at position (1,1) -> 5 pad pixels emitted, then TVALID=0 until input valid, then 1 one cycle later.
REQ-037 Two frames back-to-back, inputs 1..8 -> 32 contiguous outputs; second frame carries 5,6,7,8 at identical positions.
REQ-038 Reset asserted after 6 outputs -> next cycle TVALID=0, TDATA=0; after release sequence restarts FFF x5, then next input pixel.
REQ-039 With PAD_FILTER_TLAST_EN, REQ-034 stimulus -> TLAST=1 only on output 16 (FFF), 0 on all others; build without macro passes REQ-034.
